// File: rtl/mul_sequencer.sv
// Issue-and-collect wrapper around an external unsigned pipelined multiplier:
// converts RV32M operands to magnitudes, tracks destinations and sign-corrects results.
module mul_sequencer #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 5,
    parameter int RA_W        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              flush,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RA_W-1:0]   out_rd,
    output logic [XLEN-1:0]   out_data,
    input  logic [RA_W-1:0]   query_rs1,
    input  logic [RA_W-1:0]   query_rs2,
    output logic              hazard
);

    localparam int D     = MUL_LATENCY + 1;
    localparam int CNT_W = $clog2(D + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
    localparam int LAST  = MUL_LATENCY - 1;

    // ---------------- operand decode ----------------
    logic a_signed;
    logic b_signed;
    logic op_hi;
    logic op_neg;
    logic accept;
    logic take;

    always_comb begin
        a_signed = (in_funct3 != 3'b011);
        b_signed = (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
        op_hi    = (in_funct3 == 3'b001) || (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
        mul_a    = (a_signed && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
        mul_b    = (b_signed && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
        op_neg   = (a_signed && in_rs1[XLEN-1]) ^ (b_signed && in_rs2[XLEN-1]);
    end

    // ---------------- state ----------------
    logic [MUL_LATENCY-1:0] tag_vld_reg;
    logic [RA_W-1:0]        tag_rd_reg  [MUL_LATENCY];
    logic                   tag_neg_reg [MUL_LATENCY];
    logic                   tag_hi_reg  [MUL_LATENCY];

    logic [RA_W-1:0]        fifo_rd_mem   [D];
    logic [XLEN-1:0]        fifo_data_mem [D];
    logic [D-1:0]           fifo_vld_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       fifo_cnt_reg;
    logic [CNT_W-1:0]       inflight_cnt_reg;

    logic                   push;
    logic                   pop;
    logic [2*XLEN-1:0]      full_next;
    logic [XLEN-1:0]        result_next;
    logic [PTR_W-1:0]       wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_next;

    // Credit covers both in-flight and buffered results, since the multiplier never stalls.
    assign in_ready = !rst && !flush &&
                      (({1'b0, inflight_cnt_reg} + {1'b0, fifo_cnt_reg}) < SUM_W'(D));
    assign accept   = in_valid && in_ready;
    assign take     = accept && (in_rd != '0);

    assign out_valid = !rst && (fifo_cnt_reg != '0);
    assign out_rd    = out_valid ? fifo_rd_mem[rd_ptr_reg]   : '0;
    assign out_data  = out_valid ? fifo_data_mem[rd_ptr_reg] : '0;

    assign push = tag_vld_reg[LAST] && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        full_next   = tag_neg_reg[LAST] ? -mul_p : mul_p;
        result_next = tag_hi_reg[LAST] ? full_next[2*XLEN-1:XLEN] : full_next[XLEN-1:0];
        wr_ptr_next = (wr_ptr_reg == PTR_W'(D - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        rd_ptr_next = (rd_ptr_reg == PTR_W'(D - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end

    // ---------------- tag pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tag_vld_reg <= '0;
        end else begin
            tag_vld_reg[0] <= take;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld_reg[i] <= tag_vld_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_rd_reg[0]  <= in_rd;
        tag_neg_reg[0] <= op_neg;
        tag_hi_reg[0]  <= op_hi;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_rd_reg[i]  <= tag_rd_reg[i-1];
            tag_neg_reg[i] <= tag_neg_reg[i-1];
            tag_hi_reg[i]  <= tag_hi_reg[i-1];
        end
    end

    // ---------------- result FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= tag_rd_reg[LAST];
            fifo_data_mem[wr_ptr_reg] <= result_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fifo_vld_reg     <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_cnt_reg     <= '0;
            inflight_cnt_reg <= '0;
        end else begin
            // Pointers only coincide when empty or full; a full FIFO cannot be pushed,
            // so the set below never collides with the clear.
            if (pop) begin
                fifo_vld_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg               <= rd_ptr_next;
            end
            if (push) begin
                fifo_vld_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg               <= wr_ptr_next;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
            case ({take, push})
                2'b10:   inflight_cnt_reg <= inflight_cnt_reg + CNT_W'(1);
                2'b01:   inflight_cnt_reg <= inflight_cnt_reg - CNT_W'(1);
                default: inflight_cnt_reg <= inflight_cnt_reg;
            endcase
        end
    end

    // ---------------- hazard detection ----------------
    logic [MUL_LATENCY-1:0] tag_hit;
    logic [D-1:0]           fifo_hit;

    for (genvar gi = 0; gi < MUL_LATENCY; gi++) begin : g_tag_hit
        assign tag_hit[gi] = tag_vld_reg[gi] &&
            (((query_rs1 != '0) && (tag_rd_reg[gi] == query_rs1)) ||
             ((query_rs2 != '0) && (tag_rd_reg[gi] == query_rs2)));
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_fifo_hit
        assign fifo_hit[gi] = fifo_vld_reg[gi] &&
            (((query_rs1 != '0) && (fifo_rd_mem[gi] == query_rs1)) ||
             ((query_rs2 != '0) && (fifo_rd_mem[gi] == query_rs2)));
    end

    assign hazard = !rst && ((|tag_hit) || (|fifo_hit));

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed bench for mul_sequencer with an external 5-stage multiplier
// model and a queue-based reference of pending results.
module tb_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        hazard;

    mul_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct3 (in_funct3),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .flush     (flush),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .query_rs1 (query_rs1),
        .query_rs2 (query_rs2),
        .hazard    (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned pipelined multiplier: product visible 5 cycles after operand sampling.
    logic [63:0] mpipe [5];
    always @(posedge clk) begin
        mpipe[0] <= {32'h0, mul_a} * {32'h0, mul_b};
        for (int i = 1; i < 5; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[4];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          avail;
    } ent_t;

    ent_t        pend[$];
    int          n_vec;
    int          n_err;
    int          cyc;
    int          n_acc;
    logic        zero_next;
    logic        dir_use;
    logic [31:0] dir_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic        sa;
        logic        sb;
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] p;
        sa  = (f != 3'd3);
        sb  = (f != 3'd2) && (f != 3'd3);
        a64 = sa ? {{32{a[31]}}, a} : {32'h0, a};
        b64 = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p   = a64 * b64;
        case (f)
            3'd1, 3'd2, 3'd3: return p[63:32];
            default:          return p[31:0];
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? (32'h0 - v) : v;
    endfunction

    // One clock cycle: check outputs at negedge against the model, then advance the model.
    task automatic step();
        logic        e_ready;
        logic        e_valid;
        logic        e_haz;
        logic [31:0] e_data;
        @(negedge clk);
        e_ready = !rst && !flush && (pend.size() < 6);
        e_valid = !rst && (pend.size() > 0) && (pend[0].avail <= cyc);
        e_haz   = 1'b0;
        if (!rst) begin
            foreach (pend[i]) begin
                if (((query_rs1 != 5'd0) && (pend[i].rd == query_rs1)) ||
                    ((query_rs2 != 5'd0) && (pend[i].rd == query_rs2)))
                    e_haz = 1'b1;
            end
        end
        chk("in_ready", 64'(in_ready), 64'(e_ready));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("hazard", 64'(hazard), 64'(e_haz));
        if (e_valid) begin
            chk("out_rd", 64'(out_rd), 64'(pend[0].rd));
            chk("out_data", 64'(out_data), 64'(pend[0].data));
        end
        if (rst || zero_next) begin
            chk("rst_out_rd", 64'(out_rd), 64'(0));
            chk("rst_out_data", 64'(out_data), 64'(0));
        end
        if (in_valid) begin
            chk("mul_a", 64'(mul_a), 64'(mag(in_funct3 != 3'd3, in_rs1)));
            chk("mul_b", 64'(mul_b), 64'(mag((in_funct3 != 3'd2) && (in_funct3 != 3'd3), in_rs2)));
        end
        if (in_valid && in_ready) n_acc++;
        if (rst || flush) begin
            pend.delete();
        end else begin
            if (e_valid && out_ready) begin
                $display("cycle %0d: pop rd=%0d data=%08h", cyc, pend[0].rd, pend[0].data);
                void'(pend.pop_front());
            end
            if (in_valid && e_ready && (in_rd != 5'd0)) begin
                e_data = dir_use ? dir_exp : ref_mul(in_funct3, in_rs1, in_rs2);
                pend.push_back('{rd: in_rd, data: e_data, avail: cyc + 6});
            end
        end
        zero_next = rst;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input logic use_exp);
        in_valid  = 1'b1;
        in_funct3 = f;
        in_rs1    = a;
        in_rs2    = b;
        in_rd     = rd;
        dir_exp   = exp;
        dir_use   = use_exp;
        step();
        in_valid  = 1'b0;
        dir_use   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; n_acc = 0;
        zero_next = 1'b0; dir_use = 1'b0; dir_exp = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_funct3 = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; out_ready = 1'b1;
        query_rs1 = '0; query_rs2 = '0;
        idle(3);
        rst = 1'b0;

        // basic MUL and sign corners
        issue(3'd0, 32'd7, 32'd6, 5'd3, 32'd42, 1'b1);
        idle(8);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 1'b1);
        issue(3'd0, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'hFFFF_FFFD, 1'b1);
        idle(8);

        // backpressure: 8 offers, only 6 fit
        out_ready = 1'b0;
        n_acc = 0;
        for (int k = 1; k <= 8; k++) issue(3'd0, 32'(k), 32'(k + 1), 5'(k), 32'(k * (k + 1)), 1'b1);
        chk("bp_accepts", 64'(n_acc), 64'(6));
        idle(3);
        out_ready = 1'b1;
        idle(10);

        // flush with three ops in flight and one offered in the flush cycle
        issue(3'd0, 32'd2, 32'd3, 5'd7, 32'd6, 1'b1);
        issue(3'd1, 32'd5, 32'd9, 5'd8, 32'd0, 1'b1);
        issue(3'd3, 32'd4, 32'd4, 5'd9, 32'd0, 1'b1);
        flush = 1'b1;
        issue(3'd0, 32'd1, 32'd1, 5'd10, 32'd1, 1'b1);
        flush = 1'b0;
        idle(10);

        // hazard tracking and x0 destination
        query_rs1 = 5'd5;
        issue(3'd0, 32'd11, 32'd12, 5'd5, 32'd132, 1'b1);
        idle(8);
        query_rs1 = 5'd0;
        issue(3'd0, 32'd13, 32'd14, 5'd0, 32'd182, 1'b1);
        idle(8);

        // reset with two ops in flight
        issue(3'd0, 32'd3, 32'd3, 5'd6, 32'd9, 1'b1);
        issue(3'd0, 32'd4, 32'd4, 5'd7, 32'd16, 1'b1);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(10);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_funct3 = 3'($urandom_range(0, 7));
            in_rs1    = rnd_op();
            in_rs2    = rnd_op();
            in_rd     = 5'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            query_rs1 = 5'($urandom_range(0, 7));
            query_rs2 = 5'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
